pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage pipelined CPU.
- Decides every cycle which pipeline registers advance, hold or flush: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sources it arbitrates: load-use hazards, taken branches in EX, jumps in ID, external IRQ entry, and multi-cycle peripheral/memory waits.
- Replaces ad-hoc stall/flush logic scattered in the datapath, and keeps saturating stall/flush counters for debug readout.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- IRQ_HOLD, 1, cycles the irq_take pulse is held after entry; legal range 1..3.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- id_rs  in  5  Rs address of instruction in ID.
- id_rt  in  5  Rt address of instruction in ID.
- id_use_rs  in  1  ID instruction reads Rs.
- id_use_rt  in  1  ID instruction reads Rt.
- ex_memread  in  1  instruction in EX is a load.
- ex_wraddr  in  5  destination register of instruction in EX.
- ex_branch_taken  in  1  branch in EX resolved taken.
- id_jump  in  1  ID holds j/jal/jr/jalr.
- id_kernel  in  1  PC[31] of ID instruction (1 = kernel mode, IRQ masked).
- irq_req  in  1  level interrupt request from timer/UART.
- mem_busy  in  1  data memory/peripheral in MEM needs more cycles.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear to bubble.
- idex_flush  out  1  ID/EX clear to bubble.
- pipe_en  out  1  EX/MEM and MEM/WB load enable.
- irq_take  out  1  redirect PC to the exception vector; save ID PC as EPC.
- irq_pend  out  1  IRQ latched but not yet taken.
- stall_cnt  out  CNT_W  saturating count of load-use plus wait cycles.
- flush_cnt  out  CNT_W  saturating count of flush events.

Behaviour:
- Reset (reset==0 at a clk edge): state=RUN, irq_pend=0, irq_take=0, both counters=0. Outputs while in reset: pc_en=ifid_en=pipe_en=1, flushes=0.
- States:
  - RUN: normal operation.
  - WAIT: mem_busy freeze.
  - IRQ_ENTER: irq_take asserted for IRQ_HOLD cycles.
- Per-cycle priority in RUN, highest first; all outputs are combinational from state plus inputs (0-cycle latency):
  1. mem_busy=1: all enables=0, no flush; next state=WAIT. Any event this cycle is deferred, not lost.
  2. ex_branch_taken: ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt+1.
  3. Load-use, i.e. ex_memread and ex_wraddr!=0 and ((id_use_rs and id_rs==ex_wraddr) or (id_use_rt and id_rt==ex_wraddr)):
     - pc_en=0, ifid_en=0, idex_flush=1; stall_cnt+1.
     - Exactly one bubble. Next cycle the load has left EX, so the condition clears naturally.
  4. id_jump: ifid_flush=1 only; flush_cnt+1.
  5. IRQ: irq_pend and not id_kernel → next state=IRQ_ENTER.
  6. Otherwise: all enables=1, no flush.
- WAIT:
  - All enables=0 while mem_busy=1; stall_cnt+1 per cycle.
  - On mem_busy=0: return to RUN and evaluate RUN rules in that same cycle.
- IRQ_ENTER:
  - irq_take=1, ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt+1 on the first cycle only.
  - Clears irq_pend; returns to RUN after IRQ_HOLD cycles.
  - mem_busy during IRQ_ENTER freezes the hold counter and the enables; irq_take stays asserted.
- irq_pend:
  - Set on any cycle where irq_req=1 and not irq_take.
  - Cleared only on IRQ_ENTER completion or reset.
  - A deasserted irq_req does not cancel a latched request.
- IRQ deferral:
  - Never taken in the same cycle as a branch flush or load-use stall; it waits for the next clean RUN cycle.
  - Never taken while id_kernel=1.
- Counters: saturate at all-ones with no wrap. An increment on the same edge as reset is ignored.
- Register 0 never causes a load-use stall.
- Branch taken and jump in the same cycle: the branch wins; the jump instruction is flushed by it.

Decomposition:
- Shared package (cpu_pkg) holds:
  - the state enum {RUN, WAIT, IRQ_ENTER};
  - the localparam ZERO_REG=5'd0;
  - the exception vector constants ILLOP=32'h80000004 and XADR=32'h80000008, which datapath and controller share.
- One natural sub-module, sat_counter (CNT_W, inc, clear), instantiated twice.

Test Plan:
- Load-use: load r8 in EX (ex_memread=1, ex_wraddr=8), ID uses Rs=8 → one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1; next cycle all enables=1.
- Register 0: ex_memread=1, ex_wraddr=0, id_rs=0, id_use_rs=1 → no stall; pc_en=1, stall_cnt stays 0.
- Branch plus hazard together: ex_branch_taken=1 while the load-use condition is true → ifid_flush=idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- mem_busy for 3 cycles with irq_req pulsed during cycle 2:
  - pc_en=ifid_en=pipe_en=0 for 3 cycles; stall_cnt=3; irq_pend=1.
  - After release: one RUN cycle, then irq_take=1 (IRQ_HOLD=1), after which irq_pend=0.
- IRQ masked: irq_req=1 with id_kernel=1 for 5 cycles → irq_take stays 0 and irq_pend=1. After id_kernel drops → irq_take on the next cycle.
- Saturation and reset: CNT_W=4 with 20 load-use stalls → stall_cnt=4'hF. Then reset=0 for one edge → stall_cnt=0, state=RUN, irq_pend=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage CPU: hazard-controller state encoding,
// the hard-wired zero register index and the exception vector addresses that
// both the datapath and the sequencing controller rely on.
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT      = 2'd1,
    IRQ_ENTER = 2'd2
  } state_e;

  localparam logic [4:0]  ZERO_REG = 5'd0;
  localparam logic [31:0] ILLOP    = 32'h8000_0004;
  localparam logic [31:0] XADR     = 32'h8000_0008;

  // True when the load currently in EX writes a register the ID instruction
  // reads. r0 is hard-wired to zero, so a load targeting it never conflicts.
  function automatic logic load_use_hazard(
    input logic       ex_memread,
    input logic [4:0] ex_wraddr,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_use_rs,
    input logic       id_use_rt
  );
    return ex_memread && (ex_wraddr != ZERO_REG) &&
           ((id_use_rs && (id_rs == ex_wraddr)) ||
            (id_use_rt && (id_rt == ex_wraddr)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the datapath and the hazard controller.
//   Datapath -> controller: id_rs, id_rt, id_use_rs, id_use_rt, ex_memread,
//     ex_wraddr, ex_branch_taken, id_jump, id_kernel, irq_req, mem_busy
//   Controller -> datapath: pc_en, ifid_en, ifid_flush, idex_flush, pipe_en,
//     irq_take, irq_pend, stall_cnt, flush_cnt
// master = datapath side, slave = controller side.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_memread;
  logic [4:0]       ex_wraddr;
  logic             ex_branch_taken;
  logic             id_jump;
  logic             id_kernel;
  logic             irq_req;
  logic             mem_busy;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             pipe_en;
  logic             irq_take;
  logic             irq_pend;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_wraddr,
           ex_branch_taken, id_jump, id_kernel, irq_req, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, irq_take,
           irq_pend, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memread, ex_wraddr,
           ex_branch_taken, id_jump, id_kernel, irq_req, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_flush, pipe_en, irq_take,
           irq_pend, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Debug event counter that sticks at all-ones instead of wrapping.
//   clk   in   clock
//   clear in   synchronous clear, wins over inc
//   inc   in   count one event this cycle
//   count out  current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Each cycle it decides
// whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold or flush, arbitrating
// memory waits, taken branches, load-use hazards, jumps and IRQ entry.
//   clk    in   pipeline clock
//   reset  in   synchronous, active-low reset
//   hz     slave side of pipe_hazard_ctrl_if (hazard inputs, enable/flush
//          outputs, IRQ handshake, stall/flush debug counters)
// All enable/flush outputs are combinational from state plus inputs.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int IRQ_HOLD = 1    // 1..3
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam logic [1:0] HOLD_LAST = 2'(IRQ_HOLD - 1);

  state_e     state, state_nxt;
  logic [1:0] hold_cnt;
  logic       irq_counted;   // flush for this IRQ entry already counted
  logic       irq_pend_q;
  logic       hold_done;
  logic       load_use;
  logic       stall_inc, flush_inc;
  logic       pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, irq_take;

  always_comb begin
    load_use = load_use_hazard(hz.ex_memread, hz.ex_wraddr, hz.id_rs, hz.id_rt,
                               hz.id_use_rs, hz.id_use_rt);
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    pipe_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    irq_take   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    hold_done  = 1'b0;
    state_nxt  = state;

    if (!reset) begin
      state_nxt = RUN;               // free-running defaults while in reset
    end else if (state == IRQ_ENTER) begin
      irq_take  = 1'b1;
      flush_inc = !irq_counted;
      if (hz.mem_busy) begin
        // Freeze: hold counter and enables stop, irq_take stays up.
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        pipe_en   = 1'b0;
        stall_inc = 1'b1;
      end else begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          hold_done = 1'b1;
          state_nxt = RUN;
        end
      end
    end else if (hz.mem_busy) begin
      // RUN or WAIT: events arriving now stay on the datapath and are
      // re-evaluated once the memory releases.
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      pipe_en   = 1'b0;
      stall_inc = 1'b1;
      state_nxt = WAIT;
    end else begin
      // RUN, or WAIT on its release cycle: RUN rules apply immediately.
      state_nxt = RUN;
      if (hz.ex_branch_taken) begin
        ifid_flush = 1'b1;           // also kills a jump sitting in ID
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
      end else if (hz.id_jump) begin
        ifid_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (irq_pend_q && !hz.id_kernel) begin
        state_nxt = IRQ_ENTER;       // only from a clean cycle
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      hold_cnt    <= '0;
      irq_counted <= 1'b0;
      irq_pend_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state != IRQ_ENTER) begin
        hold_cnt    <= '0;
        irq_counted <= 1'b0;
      end else begin
        irq_counted <= 1'b1;
        if (!hz.mem_busy && !hold_done) begin
          hold_cnt <= hold_cnt + 2'd1;
        end
      end
      // A latched request survives irq_req dropping; only entry clears it.
      if (hold_done) begin
        irq_pend_q <= 1'b0;
      end else if (hz.irq_req && !irq_take) begin
        irq_pend_q <= 1'b1;
      end
    end
  end

  // Clear wins over inc, so an event on the reset edge is discarded.
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (!reset),
    .inc   (stall_inc),
    .count (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (!reset),
    .inc   (flush_inc),
    .count (hz.flush_cnt)
  );

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.pipe_en    = pipe_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_flush = idex_flush;
  assign hz.irq_take   = irq_take;
  assign hz.irq_pend   = irq_pend_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (CNT_W=4, IRQ_HOLD=1). Inputs change 1ns
// after the rising edge; combinational outputs are checked 1ns later, and
// counters/irq_pend are checked 1ns after the following edge.
// Output vector order: {pc_en, ifid_en, pipe_en, ifid_flush, idex_flush, irq_take}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [5:0] O_RUN   = 6'b111_000;
  localparam logic [5:0] O_LU    = 6'b001_010;
  localparam logic [5:0] O_BR    = 6'b111_110;
  localparam logic [5:0] O_JMP   = 6'b111_100;
  localparam logic [5:0] O_FREEZ = 6'b000_000;
  localparam logic [5:0] O_IRQ   = 6'b111_111;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .IRQ_HOLD(1)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {hz.pc_en, hz.ifid_en, hz.pipe_en,
            hz.ifid_flush, hz.idex_flush, hz.irq_take};
  endfunction

  task automatic idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
    hz.ex_memread = 1'b0; hz.ex_wraddr = 5'd0; hz.ex_branch_taken = 1'b0;
    hz.id_jump = 1'b0; hz.id_kernel = 1'b0; hz.irq_req = 1'b0;
    hz.mem_busy = 1'b0;
  endtask

  task automatic load_use_r8();
    hz.ex_memread = 1'b1; hz.ex_wraddr = 5'd8; hz.id_rs = 5'd8;
    hz.id_use_rs = 1'b1;
  endtask

  // Check combinational outputs for the current cycle, then advance one edge.
  task automatic step(input string tag, input logic [5:0] exp);
    #1;
    check(tag, 32'(outs()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic regs(input string tag, input int stall, input int flush,
                      input logic pend);
    check({tag, "_stall"}, 32'(hz.stall_cnt), 32'(stall));
    check({tag, "_flush"}, 32'(hz.flush_cnt), 32'(flush));
    check({tag, "_pend"},  32'(hz.irq_pend),  32'(pend));
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("rst_out", O_RUN);
    regs("rst", 0, 0, 1'b0);
    reset = 1'b1;

    step("idle", O_RUN);

    // Load-use on Rs: exactly one bubble, then the load has left EX.
    load_use_r8();
    step("lu_rs", O_LU);
    regs("lu_rs", 1, 0, 1'b0);
    idle();
    step("lu_after", O_RUN);
    check("lu_after_stall", 32'(hz.stall_cnt), 32'd1);

    // Load into r0 never stalls.
    hz.ex_memread = 1'b1; hz.ex_wraddr = 5'd0; hz.id_rs = 5'd0; hz.id_use_rs = 1'b1;
    step("r0", O_RUN);
    check("r0_stall", 32'(hz.stall_cnt), 32'd1);

    // Rt match with and without use_rt.
    idle();
    hz.ex_memread = 1'b1; hz.ex_wraddr = 5'd5; hz.id_rs = 5'd9; hz.id_use_rs = 1'b1;
    hz.id_rt = 5'd5; hz.id_use_rt = 1'b1;
    step("lu_rt", O_LU);
    check("lu_rt_stall", 32'(hz.stall_cnt), 32'd2);
    hz.id_use_rt = 1'b0;
    step("rt_unused", O_RUN);
    check("rt_unused_stall", 32'(hz.stall_cnt), 32'd2);

    // Branch beats load-use.
    idle(); load_use_r8(); hz.ex_branch_taken = 1'b1;
    step("br_lu", O_BR);
    regs("br_lu", 2, 1, 1'b0);

    // Branch beats jump.
    idle(); hz.ex_branch_taken = 1'b1; hz.id_jump = 1'b1;
    step("br_jmp", O_BR);
    check("br_jmp_flush", 32'(hz.flush_cnt), 32'd2);

    // Jump alone, then load-use beating a jump.
    idle(); hz.id_jump = 1'b1;
    step("jmp", O_JMP);
    check("jmp_flush", 32'(hz.flush_cnt), 32'd3);
    load_use_r8();
    step("lu_jmp", O_LU);
    regs("lu_jmp", 3, 3, 1'b0);

    // mem_busy for 3 cycles, irq_req pulsed in cycle 2.
    idle(); hz.mem_busy = 1'b1;
    step("busy1", O_FREEZ);
    hz.irq_req = 1'b1;
    step("busy2", O_FREEZ);
    check("busy2_pend", 32'(hz.irq_pend), 32'd1);
    hz.irq_req = 1'b0;
    step("busy3", O_FREEZ);
    regs("busy3", 6, 3, 1'b1);
    hz.mem_busy = 1'b0;
    step("busy_rel", O_RUN);
    step("busy_irq", O_IRQ);
    regs("busy_irq", 6, 4, 1'b0);
    step("busy_post", O_RUN);

    // Kernel mode masks a latched IRQ.
    hz.irq_req = 1'b1; hz.id_kernel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("kmask", O_RUN);
    end
    check("kmask_pend", 32'(hz.irq_pend), 32'd1);
    idle();
    step("kunmask", O_RUN);
    step("kirq", O_IRQ);
    regs("kirq", 6, 5, 1'b0);

    // Load-use defers a pending IRQ to the next clean cycle.
    hz.irq_req = 1'b1;
    step("dq_req", O_RUN);
    idle(); load_use_r8();
    step("dq_lu", O_LU);
    idle();
    step("dq_clean", O_RUN);
    step("dq_irq", O_IRQ);
    regs("dq", 7, 6, 1'b0);

    // Saturation: 20 back-to-back stalls.
    load_use_r8();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
    end
    #1;
    check("sat_stall", 32'(hz.stall_cnt), 32'hF);
    hz.irq_req = 1'b1; hz.id_kernel = 1'b1;
    step("sat_lu", O_LU);
    regs("sat", 15, 6, 1'b1);

    // Reset with an increment on the same edge.
    hz.irq_req = 1'b0;
    reset = 1'b0;
    step("rst2_out", O_RUN);
    regs("rst2", 0, 0, 1'b0);
    reset = 1'b1;
    idle();
    step("rst2_run", O_RUN);
    regs("rst2_run", 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
